// File: rtl/nc_ifetch_l2_adapter_if.sv
// Bus bundle between the NC bypass buffer, the L2/NoC read port and the adapter.
// The master modport is the adapter's view; slave is the surrounding fabric.
interface nc_ifetch_l2_adapter_if #(
    parameter int BEAT_W = 32,
    parameter int TID_W  = 2
);
    logic              nc_req_valid_i;
    logic [39:0]       nc_req_paddr_i;
    logic              l2_req_valid_o;
    logic              l2_req_ready_i;
    logic [39:0]       l2_req_paddr_o;
    logic [2:0]        l2_req_size_o;
    logic [TID_W-1:0]  l2_req_tid_o;
    logic              l2_resp_valid_i;
    logic [TID_W-1:0]  l2_resp_tid_i;
    logic [BEAT_W-1:0] l2_resp_data_i;
    logic              grant_valid_o;
    logic [63:0]       grant_data_o;
    logic              busy_o;
    logic              timeout_o;
    logic              drop_o;

    modport master (
        input  nc_req_valid_i, nc_req_paddr_i,
        output l2_req_valid_o, l2_req_paddr_o, l2_req_size_o, l2_req_tid_o,
        input  l2_req_ready_i,
        input  l2_resp_valid_i, l2_resp_tid_i, l2_resp_data_i,
        output grant_valid_o, grant_data_o, busy_o, timeout_o, drop_o
    );

    modport slave (
        output nc_req_valid_i, nc_req_paddr_i,
        input  l2_req_valid_o, l2_req_paddr_o, l2_req_size_o, l2_req_tid_o,
        output l2_req_ready_i,
        output l2_resp_valid_i, l2_resp_tid_i, l2_resp_data_i,
        input  grant_valid_o, grant_data_o, busy_o, timeout_o, drop_o
    );
endinterface

// File: rtl/nc_ifetch_l2_adapter.sv
// Converts a single-cycle non-cacheable fetch pulse into one tagged 8-byte L2 read,
// assembles the response beats into a line and returns it with a one-cycle grant.
module nc_ifetch_l2_adapter #(
    parameter int BEAT_W      = 32,
    parameter int TID_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    nc_ifetch_l2_adapter_if.master  bus
);
    localparam int BEATS = 64 / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [TID_W-1:0] tid_r;
    logic [39:0]      paddr_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [TMR_W-1:0] timer_r;
    logic [63:0]      line_r;
    logic [63:0]      line_merged_s;
    logic             grant_valid_r;
    logic [63:0]      grant_data_r;
    logic             timeout_r;
    logic             drop_r;
    logic             handshake_s;
    logic             beat_ok_s;
    logic             last_beat_s;
    logic             timeout_hit_s;
    logic             drop_s;

    // Beat qualification, timeout detection and line merge for the current cycle.
    always_comb begin
        handshake_s   = (state_r == ST_REQ) && bus.l2_req_ready_i;
        beat_ok_s     = (state_r == ST_WAIT) && bus.l2_resp_valid_i &&
                        (bus.l2_resp_tid_i == tid_r);
        last_beat_s   = beat_ok_s && (beat_cnt_r == CNT_LAST);
        // A last beat landing on the timeout cycle completes the line normally.
        timeout_hit_s = TO_EN && (state_r == ST_WAIT) && (timer_r == TMR_LAST) && !last_beat_s;
        drop_s        = bus.nc_req_valid_i && (state_r != ST_IDLE);
        line_merged_s = line_r;
        if (beat_ok_s) begin
            line_merged_s[int'(beat_cnt_r) * BEAT_W +: BEAT_W] = bus.l2_resp_data_i;
        end else begin
            line_merged_s = line_r;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.nc_req_valid_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (handshake_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (last_beat_s || timeout_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Transaction state, line assembly and registered grant/status pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r       <= ST_IDLE;
            tid_r         <= '0;
            paddr_r       <= 40'd0;
            beat_cnt_r    <= '0;
            timer_r       <= '0;
            line_r        <= 64'd0;
            grant_valid_r <= 1'b0;
            grant_data_r  <= 64'd0;
            timeout_r     <= 1'b0;
            drop_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
            drop_r        <= drop_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.nc_req_valid_i) begin
                        paddr_r <= bus.nc_req_paddr_i;
                        tid_r   <= tid_r + TID_W'(1);
                    end
                end
                ST_REQ: begin
                    if (handshake_s) begin
                        beat_cnt_r <= '0;
                        timer_r    <= '0;
                        line_r     <= 64'd0;
                    end
                end
                ST_WAIT: begin
                    timer_r <= timer_r + TMR_W'(1);
                    if (beat_ok_s) begin
                        line_r     <= line_merged_s;
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end
                    if (last_beat_s || timeout_hit_s) begin
                        grant_valid_r <= 1'b1;
                        grant_data_r  <= line_merged_s;
                        timeout_r     <= timeout_hit_s;
                    end
                end
                ST_DONE: begin
                    grant_valid_r <= 1'b0;
                end
                default: begin
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.l2_req_valid_o = (state_r == ST_REQ);
    assign bus.l2_req_paddr_o = paddr_r;
    assign bus.l2_req_size_o  = 3'd3;
    assign bus.l2_req_tid_o   = tid_r;
    assign bus.grant_valid_o  = grant_valid_r;
    assign bus.grant_data_o   = grant_data_r;
    assign bus.busy_o         = (state_r != ST_IDLE);
    assign bus.timeout_o      = timeout_r;
    assign bus.drop_o         = drop_r;
endmodule
